// File: rtl/alu_arbiter.sv
// Two-requester round-robin front end for a single shared combinational ALU.
// One operation takes three cycles: accept (IDLE->EXEC), compute/capture (EXEC), report (DONE).
module alu_arbiter #(
    parameter int WIDTH = 32,
    parameter int CTL_W = 5
) (
    input  logic                 iCLK,
    input  logic                 iRST,
    input  logic [1:0]           iReq,
    input  logic [2*CTL_W-1:0]   iCtl,
    input  logic [2*WIDTH-1:0]   iA,
    input  logic [2*WIDTH-1:0]   iB,
    output logic [1:0]           oAck,
    output logic [1:0]           oValid,
    output logic [WIDTH-1:0]     oResult,
    output logic                 oZero,
    output logic [CTL_W-1:0]     oAluCtl,
    output logic [WIDTH-1:0]     oAluA,
    output logic [WIDTH-1:0]     oAluB,
    input  logic [WIDTH-1:0]     iAluResult,
    input  logic                 iAluZero,
    output logic [1:0]           oDbgState
);

    // Handshake: a requester raises iReq[i] with stable iCtl/iA/iB and holds them until
    // oAck[i]; oAck[i] pulses in the cycle the operands are consumed, and oValid[i] pulses
    // once, one cycle later, marking oResult/oZero as belonging to requester i.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_next;
    logic               r_winner;
    logic               r_last;
    logic [CTL_W-1:0]   r_ctl;
    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;
    logic [WIDTH-1:0]   r_result;
    logic               r_zero;

    logic               w_win;
    logic               w_start;
    logic [CTL_W-1:0]   w_ctl_sel;
    logic [WIDTH-1:0]   w_a_sel;
    logic [WIDTH-1:0]   w_b_sel;

    // On a tie the requester that was not granted last wins.
    always_comb begin
        if (iReq == 2'b01) begin
            w_win = 1'b0;
        end else if (iReq == 2'b10) begin
            w_win = 1'b1;
        end else begin
            w_win = ~r_last;
        end
    end

    assign w_start   = (r_state == ST_IDLE) && (iReq != 2'b00);
    assign w_ctl_sel = w_win ? iCtl[2*CTL_W-1:CTL_W] : iCtl[CTL_W-1:0];
    assign w_a_sel   = w_win ? iA[2*WIDTH-1:WIDTH]   : iA[WIDTH-1:0];
    assign w_b_sel   = w_win ? iB[2*WIDTH-1:WIDTH]   : iB[WIDTH-1:0];

    always_comb begin
        w_next = ST_IDLE;
        case (r_state)
            ST_IDLE: w_next = (iReq != 2'b00) ? ST_EXEC : ST_IDLE;
            ST_EXEC: w_next = ST_DONE;
            ST_DONE: w_next = ST_IDLE;
            default: w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge iCLK or negedge iRST) begin
        if (!iRST) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Pointer resets to 1 so requester 0 wins the first tie.
    always_ff @(posedge iCLK or negedge iRST) begin
        if (!iRST) begin
            r_winner <= 1'b0;
            r_last   <= 1'b1;
            r_ctl    <= '0;
            r_a      <= '0;
            r_b      <= '0;
            r_result <= '0;
            r_zero   <= 1'b0;
        end else begin
            if (w_start) begin
                r_winner <= w_win;
                r_ctl    <= w_ctl_sel;
                r_a      <= w_a_sel;
                r_b      <= w_b_sel;
            end
            if (r_state == ST_EXEC) begin
                r_result <= iAluResult;
                r_zero   <= iAluZero;
            end
            if (r_state == ST_DONE) begin
                r_last <= r_winner;
            end
        end
    end

    always_comb begin
        oAck   = 2'b00;
        oValid = 2'b00;
        if (r_state == ST_EXEC) begin
            oAck[r_winner] = 1'b1;
        end
        if (r_state == ST_DONE) begin
            oValid[r_winner] = 1'b1;
        end
    end

    assign oResult   = r_result;
    assign oZero     = r_zero;
    assign oAluCtl   = r_ctl;
    assign oAluA     = r_a;
    assign oAluB     = r_b;
    assign oDbgState = r_state;

endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 Parameter: WIDTH, 32, operand/result width; fixed to match the shared ALU.
REQ-002 Parameter: CTL_W, 5, ALU control code width.
REQ-003 iCLK  input  1  single clock; all state updates on rising edge.
REQ-004 iRST  input  1  reset, asynchronous, active-low.
REQ-005 iReq  input  2  request per requester, bit 0 = requester 0, bit 1 = requester 1.
REQ-006 iCtl  input  2*CTL_W  ALU control codes, {req1, req0}.
REQ-007 iA  input  2*WIDTH  operand A, {req1, req0}.
REQ-008 iB  input  2*WIDTH  operand B, {req1, req0}.
REQ-009 oAck  output  2  one-cycle accept pulse to the granted requester.
REQ-010 oValid  output  2  one-cycle result-valid pulse to the granted requester.
REQ-011 oResult  output  WIDTH  captured ALU result; shared, qualified by oValid.
REQ-012 oZero  output  1  captured ALU zero flag; shared, qualified by oValid.
REQ-013 oAluCtl  output  CTL_W  control code driven to the shared ALU.
REQ-014 oAluA  output  WIDTH  operand A driven to the shared ALU.
REQ-015 oAluB  output  WIDTH  operand B driven to the shared ALU.
REQ-016 iAluResult  input  WIDTH  ALU result, combinational from oAluCtl/oAluA/oAluB.
REQ-017 iAluZero  input  1  ALU zero flag.

Function
REQ-018 FSM SHALL have three states: IDLE, EXEC, DONE; unreachable encodings SHALL go to IDLE on the next edge.
REQ-019 IDLE: at a rising edge with iReq != 0, the arbiter SHALL select a winner, latch its iCtl/iA/iB into registers, record the winner index, and enter EXEC.
REQ-020 Arbitration: single request -> that requester; both -> the requester not granted most recently (round-robin).
REQ-021 IDLE with iReq == 0 SHALL remain in IDLE with no register change.
REQ-022 EXEC lasts exactly one cycle: oAck[winner]=1, oAluCtl/oAluA/oAluB = latched values; at the closing edge iAluResult/iAluZero SHALL be captured into oResult/oZero; next state DONE.
REQ-023 DONE lasts exactly one cycle: oValid[winner]=1; last-granted pointer updated to winner; next state IDLE.
REQ-024 Latency: request sampled at edge N -> oAck high in cycle N..N+1, oValid high in cycle N+1..N+2; throughput one operation per 3 cycles under continuous requests.
REQ-025 oAck and oValid SHALL be Moore outputs (state + winner register only), never both bits high, never high outside EXEC/DONE respectively.
REQ-026 Requesters SHALL hold iReq and operands stable until oAck; operands SHALL be sampled only at the IDLE->EXEC edge, so changes afterwards SHALL NOT affect the result.
REQ-027 A requester deasserting iReq before being granted SHALL not be serviced; a request held high during DONE SHALL be re-arbitrated in the following IDLE cycle.
REQ-028 oResult/oZero SHALL hold their value until the next EXEC capture; oAluCtl/oAluA/oAluB SHALL hold the last latched values outside EXEC.
REQ-029 Result width: oResult is the unmodified WIDTH-bit iAluResult; no sign extension or truncation.

Reset
REQ-030 iRST low SHALL immediately force state IDLE, oAck=0, oValid=0, oResult=0, oZero=0, operand/control registers=0, last-granted pointer=1 (requester 0 wins first tie).
REQ-031 Reset asserted in EXEC or DONE SHALL abandon the operation; no oValid SHALL be produced for it after reset release.
REQ-032 First arbitration SHALL occur at the first rising edge after iRST is high.

Verification
REQ-033 Single: iReq=01, ctl=ADD, A=5, B=7 -> oAck=01 one cycle, next cycle oValid=01, oResult=12, oZero=0.
REQ-034 Tie after reset: iReq=11 held -> grants in order 0,1,0,1, each oValid one cycle, 3 cycles apart.
REQ-035 Zero flag: requester 1, SUB, A=B=0x0000_0009 -> oValid=10, oResult=0, oZero=1.
REQ-036 Operand change after accept: requester 0 AND 0xF0F0_F0F0 & 0xFF00_FF00, iA changed to 0 in EXEC -> oResult=0xF000_F000.
REQ-037 Reset in EXEC: iRST low during EXEC, released 2 cycles later with iReq=00 -> outputs all zero, no oValid pulse, state IDLE.
REQ-038 Signed SLT via arbiter: requester 0, A=0xFFFF_FFFF, B=1 -> oResult=1; repeated with operands swapped -> oResult=0.
